// File: rtl/icache_refill_ctrl.sv
// Direct-mapped instruction cache controller: same-cycle hits from a combinational
// data array, word-by-word line refill over a req/ready handshake, flush and counters.
module icache_refill_ctrl #(
    parameter int ADDR_W     = 32,
    parameter int LINE_WORDS = 4,
    parameter int NUM_LINES  = 16
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic [31:0]       cpu_inst,
    output logic              cpu_stall,
    input  logic              flush,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
);

    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = ADDR_W - 2 - OFF_W - IDX_W;
    localparam int DEPTH = NUM_LINES * LINE_WORDS;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REFILL,
        S_FLUSH
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_LINES-1:0] valid_q, valid_d;
    logic                 mem_req_q, mem_req_d;
    logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
    logic [OFF_W-1:0]     wcnt_q, wcnt_d;
    logic                 pend_q, pend_d;
    logic [IDX_W-1:0]     fill_idx_q, fill_idx_d;
    logic [TAG_W-1:0]     fill_tag_q, fill_tag_d;
    logic [31:0]          hit_cnt_q, hit_cnt_d;
    logic [31:0]          miss_cnt_q, miss_cnt_d;

    logic [31:0]          data_mem [DEPTH];
    logic [TAG_W-1:0]     tag_mem  [NUM_LINES];

    logic [OFF_W-1:0]     req_off;
    logic [IDX_W-1:0]     req_idx;
    logic [TAG_W-1:0]     req_tag;
    logic [OFF_W-1:0]     wcnt_inc;
    logic                 last_word;
    logic                 hit;
    logic                 data_we;
    logic                 tag_we;
    logic                 unused_addr_lsb;

    assign req_off   = cpu_addr[OFF_W+1:2];
    assign req_idx   = cpu_addr[OFF_W+IDX_W+1:OFF_W+2];
    assign req_tag   = cpu_addr[ADDR_W-1:ADDR_W-TAG_W];
    assign wcnt_inc  = wcnt_q + OFF_W'(1);
    assign last_word = (wcnt_q == OFF_W'(LINE_WORDS - 1));
    assign unused_addr_lsb = ^cpu_addr[1:0];

    assign hit       = (state_q == S_IDLE) & cpu_req & valid_q[req_idx]
                       & (tag_mem[req_idx] == req_tag);
    assign cpu_inst  = hit ? data_mem[{req_idx, req_off}] : 32'd0;
    assign cpu_stall = (cpu_req & ~hit) | (state_q != S_IDLE);

    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;
    assign hit_cnt   = hit_cnt_q;
    assign miss_cnt  = miss_cnt_q;

    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        wcnt_d     = wcnt_q;
        pend_d     = pend_q;
        fill_idx_d = fill_idx_q;
        fill_tag_d = fill_tag_q;
        miss_cnt_d = miss_cnt_q;
        data_we    = 1'b0;
        tag_we     = 1'b0;
        hit_cnt_d  = (hit && hit_cnt_q != 32'hFFFF_FFFF) ? hit_cnt_q + 32'd1 : hit_cnt_q;

        case (state_q)
            S_IDLE: begin
                // Flush takes priority over a simultaneous miss.
                if (flush) begin
                    valid_d = '0;
                    state_d = S_FLUSH;
                end else if (cpu_req && !hit) begin
                    fill_idx_d       = req_idx;
                    fill_tag_d       = req_tag;
                    wcnt_d           = '0;
                    valid_d[req_idx] = 1'b0;
                    mem_req_d        = 1'b1;
                    mem_addr_d       = {req_tag, req_idx, {OFF_W{1'b0}}, 2'b00};
                    if (miss_cnt_q != 32'hFFFF_FFFF) begin
                        miss_cnt_d = miss_cnt_q + 32'd1;
                    end
                    state_d = S_REFILL;
                end
            end
            S_REFILL: begin
                if (flush) begin
                    pend_d = 1'b1;
                end
                if (mem_ready) begin
                    data_we    = 1'b1;
                    wcnt_d     = wcnt_inc;
                    mem_addr_d = {fill_tag_q, fill_idx_q, wcnt_inc, 2'b00};
                    if (last_word) begin
                        tag_we    = 1'b1;
                        mem_req_d = 1'b0;
                        pend_d    = 1'b0;
                        // A flush seen at any point of the refill leaves the line invalid.
                        if (pend_q || flush) begin
                            state_d = S_FLUSH;
                        end else begin
                            valid_d[fill_idx_q] = 1'b1;
                            state_d             = S_IDLE;
                        end
                    end
                end
            end
            S_FLUSH: begin
                valid_d = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            valid_q    <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            wcnt_q     <= '0;
            pend_q     <= 1'b0;
            fill_idx_q <= '0;
            fill_tag_q <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            wcnt_q     <= wcnt_d;
            pend_q     <= pend_d;
            fill_idx_q <= fill_idx_d;
            fill_tag_q <= fill_tag_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    // Data and tag storage are deliberately not reset; the valid bits guard them.
    always_ff @(posedge clk_in) begin
        if (data_we) begin
            data_mem[{fill_idx_q, wcnt_q}] <= mem_rdata;
        end
    end

    always_ff @(posedge clk_in) begin
        if (tag_we) begin
            tag_mem[fill_idx_q] <= fill_tag_q;
        end
    end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Randomized bench for icache_refill_ctrl against a transparent-cache reference model,
// plus a short directed run on an 8-word x 4-line configuration.
module tb_icache_refill_ctrl;

    localparam int AW  = 32;
    localparam int LW  = 4;
    localparam int NL  = 16;
    localparam int LW2 = 8;
    localparam int NL2 = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default-geometry instance
    logic          reset, cpu_req, flush, mem_ready;
    logic [AW-1:0] cpu_addr;
    logic [31:0]   mem_rdata;
    logic [31:0]   cpu_inst, hit_cnt, miss_cnt;
    logic          cpu_stall, mem_req;
    logic [AW-1:0] mem_addr;

    // Small-geometry instance
    logic          b_reset, b_cpu_req, b_flush, b_mem_ready;
    logic [AW-1:0] b_cpu_addr;
    logic [31:0]   b_mem_rdata;
    logic [31:0]   b_cpu_inst, b_hit_cnt, b_miss_cnt;
    logic          b_cpu_stall, b_mem_req;
    logic [AW-1:0] b_mem_addr;

    icache_refill_ctrl #(.ADDR_W(AW), .LINE_WORDS(LW), .NUM_LINES(NL)) dut (
        .clk_in(clk), .reset(reset), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
        .cpu_inst(cpu_inst), .cpu_stall(cpu_stall), .flush(flush),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    icache_refill_ctrl #(.ADDR_W(AW), .LINE_WORDS(LW2), .NUM_LINES(NL2)) dut_b (
        .clk_in(clk), .reset(b_reset), .cpu_req(b_cpu_req), .cpu_addr(b_cpu_addr),
        .cpu_inst(b_cpu_inst), .cpu_stall(b_cpu_stall), .flush(b_flush),
        .mem_req(b_mem_req), .mem_addr(b_mem_addr), .mem_ready(b_mem_ready),
        .mem_rdata(b_mem_rdata), .hit_cnt(b_hit_cnt), .miss_cnt(b_miss_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Backing store contents: a fixed scramble of the word address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    // Reference model: the cache is transparent, so a hit returns mem_word(address).
    bit          m_busy, m_flushing, m_pend;
    logic [31:0] m_base;
    int          m_done;
    bit          m_valid [NL];
    logic [31:0] m_line  [NL];
    logic [31:0] m_hits, m_misses;

    task automatic model_reset();
        m_busy = 0; m_flushing = 0; m_pend = 0; m_done = 0; m_base = '0;
        m_hits = '0; m_misses = '0;
        for (int i = 0; i < NL; i++) m_valid[i] = 0;
    endtask

    task automatic run_main(input int cycles);
        bit          reset_now, hit_e;
        logic [31:0] a_w, ln;
        int          idx, bidx;
        for (int cyc = 0; cyc < cycles; cyc++) begin
            @(negedge clk);
            reset_now = (cyc < 2) || ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 3) == 0) begin
                cpu_addr = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 'h3FF));
            end
            cpu_req   = ($urandom_range(0, 9) < 8);
            flush     = ($urandom_range(0, 39) == 0);
            mem_ready = $urandom_range(0, 1);
            mem_rdata = m_busy ? mem_word(m_base + 32'(4 * m_done)) : $urandom;
            reset     = reset_now;
            #1;
            if (reset_now) model_reset();

            a_w   = cpu_addr & 32'hFFFF_FFFC;
            ln    = a_w / (4 * LW);
            idx   = int'(ln % NL);
            hit_e = !m_busy && !m_flushing && cpu_req && m_valid[idx] && (m_line[idx] == ln);

            check_eq("cpu_stall", 32'(cpu_stall), 32'((cpu_req && !hit_e) || m_busy || m_flushing));
            check_eq("cpu_inst", cpu_inst, hit_e ? mem_word(a_w) : 32'd0);
            check_eq("mem_req", 32'(mem_req), 32'(m_busy));
            if (m_busy) check_eq("mem_addr", mem_addr, m_base + 32'(4 * m_done));
            if (reset_now && cyc == 1) check_eq("reset_mem_addr", mem_addr, 32'd0);
            check_eq("hit_cnt", hit_cnt, m_hits);
            check_eq("miss_cnt", miss_cnt, m_misses);

            if (!reset_now) begin
                if (m_flushing) begin
                    for (int i = 0; i < NL; i++) m_valid[i] = 0;
                    m_flushing = 0;
                end else if (m_busy) begin
                    if (flush) m_pend = 1;
                    if (mem_ready) begin
                        m_done++;
                        if (m_done == LW) begin
                            m_busy = 0;
                            bidx   = int'((m_base / (4 * LW)) % NL);
                            $display("refill base=%h %s", m_base, m_pend ? "dropped by flush" : "valid");
                            if (m_pend) begin
                                m_flushing = 1;
                                m_pend     = 0;
                            end else begin
                                m_valid[bidx] = 1;
                                m_line[bidx]  = m_base / (4 * LW);
                            end
                        end
                    end
                end else begin
                    if (hit_e && m_hits != 32'hFFFF_FFFF) m_hits++;
                    if (flush) begin
                        for (int i = 0; i < NL; i++) m_valid[i] = 0;
                        m_flushing = 1;
                    end else if (cpu_req && !hit_e) begin
                        m_busy       = 1;
                        m_base       = a_w - (a_w % (4 * LW));
                        m_done       = 0;
                        m_valid[idx] = 0;
                        if (m_misses != 32'hFFFF_FFFF) m_misses++;
                    end
                end
            end
        end
    endtask

    task automatic run_small();
        int w, guard;
        @(negedge clk);
        b_reset = 1'b0; b_cpu_req = 1'b0; b_flush = 1'b0;
        // Stray ready pulses with no request outstanding must be ignored.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            b_mem_ready = 1'b1; b_mem_rdata = 32'hDEAD_0000 + 32'(i);
            #1;
            check_eq("b_idle_mem_req", 32'(b_mem_req), 32'd0);
            check_eq("b_idle_stall", 32'(b_cpu_stall), 32'd0);
        end
        @(negedge clk);
        b_mem_ready = 1'b0; b_cpu_req = 1'b1; b_cpu_addr = 32'h44;
        #1;
        check_eq("b_miss_stall", 32'(b_cpu_stall), 32'd1);
        check_eq("b_miss_inst", b_cpu_inst, 32'd0);
        w = 0; guard = 0;
        while (w < LW2 && guard < 100) begin
            @(negedge clk);
            b_mem_ready = (guard > 40) ? 1'b1 : 1'($urandom_range(0, 1));
            b_mem_rdata = 32'hB0 + 32'(w);
            #1;
            check_eq("b_mem_req", 32'(b_mem_req), 32'd1);
            check_eq("b_mem_addr", b_mem_addr, 32'h40 + 32'(4 * w));
            check_eq("b_refill_stall", 32'(b_cpu_stall), 32'd1);
            if (b_mem_ready) w++;
            guard++;
        end
        check_eq("b_refill_done", 32'(w), 32'(LW2));
        $display("refill base=%h small geometry, %0d cycles", 32'h40, guard);
        @(negedge clk);
        b_mem_ready = 1'b0;
        #1;
        check_eq("b_after_mem_req", 32'(b_mem_req), 32'd0);
        check_eq("b_hit_stall", 32'(b_cpu_stall), 32'd0);
        check_eq("b_hit_inst", b_cpu_inst, 32'hB1);
        check_eq("b_miss_cnt", b_miss_cnt, 32'd1);
        check_eq("b_hit_cnt0", b_hit_cnt, 32'd0);
        @(negedge clk);
        b_cpu_addr = 32'h5C;
        #1;
        check_eq("b_hit_inst_last", b_cpu_inst, 32'hB7);
        check_eq("b_hit_cnt1", b_hit_cnt, 32'd1);
    endtask

    initial begin
        reset = 1'b1; cpu_req = 1'b0; cpu_addr = '0; flush = 1'b0;
        mem_ready = 1'b0; mem_rdata = '0;
        b_reset = 1'b1; b_cpu_req = 1'b0; b_cpu_addr = '0; b_flush = 1'b0;
        b_mem_ready = 1'b0; b_mem_rdata = '0;
        model_reset();
        for (int i = 0; i < NL; i++) m_line[i] = '0;
        run_main(4000);
        run_small();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/icache_refill_ctrl.md
Name: icache_refill_ctrl

Overview:
Parametrised direct-mapped instruction cache controller between the CPU fetch port and the DDR2/SD backing store. It replaces the fixed, PC-indexed hit/stall path with a configurable cache: geometry is set by parameters, lines refill word-by-word over a req/ready handshake, and the block supports flush and hit/miss counters. It drives the CPU stall directly and runs entirely on clk_in.

Parameters:
ADDR_W, 32, CPU byte-address width
LINE_WORDS, 4, 32-bit words per line (power of 2, >=2)
NUM_LINES, 16, number of lines (power of 2, >=2)

Ports:
clk_in  input  1  system clock; all state updates on its rising edge
reset  input  1  asynchronous, active-high reset
cpu_req  input  1  fetch request valid
cpu_addr  input  ADDR_W  fetch byte address; bits [1:0] ignored
cpu_inst  output  32  fetched instruction; 0 when not a hit
cpu_stall  output  1  CPU must hold PC
flush  input  1  invalidate all lines (single-cycle pulse)
mem_req  output  1  backing-store word read request
mem_addr  output  ADDR_W  word-aligned byte address of the requested word
mem_ready  input  1  mem_rdata valid; completes the current request
mem_rdata  input  32  backing-store read data
hit_cnt  output  32  saturating hit counter
miss_cnt  output  32  saturating miss counter

Behaviour:
- Address split: OFF = log2(LINE_WORDS) bits at [OFF+1:2]; IDX = log2(NUM_LINES) bits above OFF; TAG = remaining upper bits.
- Storage: data array NUM_LINES*LINE_WORDS x 32 with combinational read; per-line tag and valid bit.
- States: IDLE, REFILL, FLUSH.
- hit = (state==IDLE) & cpu_req & valid[idx] & (tag[idx]==addr tag), combinational. On hit: cpu_inst = word at idx/offset, in the same cycle.
- cpu_stall = (cpu_req & ~hit) | (state!=IDLE), combinational.
- IDLE, cpu_req & miss: latch line base (cpu_addr with offset and byte bits zeroed), clear word counter, miss_cnt+1, go to REFILL.
- REFILL: mem_req=1 and mem_addr = base + 4*wcnt. Each cycle with mem_ready=1 writes mem_rdata into word wcnt and increments wcnt. After word LINE_WORDS-1 is accepted, write tag, set valid, go to IDLE. mem_req drops in the cycle after the last accept. The earliest hit is the cycle after return to IDLE.
- Line fill order is always word 0 upward. cpu_addr changes during REFILL are ignored. The refill completes for the latched line, then IDLE re-evaluates the current address.
- mem_ready while mem_req=0 is ignored.
- Flush in IDLE: go to FLUSH and clear all valid bits that cycle, with cpu_stall=1. Next cycle returns to IDLE.
- Flush during REFILL: set a pending flag. The refill finishes, but the line is NOT marked valid; the FLUSH state then executes. Flush and a miss in the same IDLE cycle: flush wins and the miss is not counted.
- Counters: hit_cnt increments on every cycle with hit=1; miss_cnt increments once per refill start. Both saturate at 0xFFFFFFFF.
- Reset (any state, including mid-refill): state IDLE; valid all 0; mem_req 0; mem_addr 0; wcnt 0; pending flush 0; hit_cnt and miss_cnt 0. cpu_inst is 0 and cpu_stall = cpu_req. Data and tag arrays are not cleared.

Test Plan:
1. Defaults. Reset, then cpu_req=1, addr 0x00000010 -> cpu_stall=1; mem_addr sequence 0x10, 0x14, 0x18, 0x1C; memory returns 0xA0..0xA3 with 2-cycle ready latency. Cycle after the 4th accept: cpu_stall=0, cpu_inst=0xA0, miss_cnt=1.
2. Follow-up addr 0x1C -> same-cycle hit, cpu_inst=0xA3, hit_cnt increments each cycle held.
3. Conflict: addr 0x110 (index 1, tag 1) -> refill 0x110..0x11C. Then addr 0x10 misses again; miss_cnt=3.
4. Pulse flush after the 2nd word of a refill -> refill completes, line stays invalid. One FLUSH cycle follows, then the same addr misses again and a new refill starts at base+0.
5. Assert reset during the 3rd refill word -> mem_req=0 immediately, counters 0. Next request to a previously valid line misses.
6. Param LINE_WORDS=8, NUM_LINES=4; pulse mem_ready with mem_req=0 -> no write occurs. A miss at 0x44 refills 0x40..0x5C, and cpu_inst returns word 1.
